// File: rtl/synth_pkg.sv
// Shared types for the synth control slice: waveform codes,
// the mode controller state and a waveform-advance helper.
package synth_pkg;

   typedef enum logic [1:0] {
      WAVE_SQUARE = 2'd0,
      WAVE_SAW    = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_SINE   = 2'd3
   } wave_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_WRAP = 2'd1,
      ST_COMMIT    = 2'd2
   } ctrl_state_t;

   // Next waveform in the cycle; sine wraps back to square.
   function automatic wave_t wave_next(input wave_t w);
      return wave_t'(w + 2'd1);
   endfunction

endpackage

// File: rtl/wave_mode_ctrl_key_debounce.sv
// key_debounce: 2-flop synchronizer, counter debounce and rising-edge
// press detect. Ports: clk, rst (sync, high), key (raw), press (1-cycle).
module key_debounce
   import synth_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   localparam int unsigned DW =
      (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;
   logic          press_q;
   logic          press_d;

   // The count holds the number of consecutive samples that disagree
   // with the accepted level; any agreeing sample clears it.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/wave_mode_ctrl.sv
// wave_mode_ctrl: steps the oscillator waveform on each key press,
// deferring the switch to a phase wrap so the change is click-free.
// Ports: clk, rst (sync, high), mode_key (raw button), phase_wrap
// (wrap pulse), osc_en (note on), wave_sel, wave_chg (pulse), busy.
module wave_mode_ctrl
   import synth_pkg::*;
#(
   parameter int unsigned DB_CYCLES      = 100000,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  mode_key,
   input  logic  phase_wrap,
   input  logic  osc_en,
   output wave_t wave_sel,
   output logic  wave_chg,
   output logic  busy
);

   localparam int unsigned TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          press;

   ctrl_state_t   state_q;
   ctrl_state_t   state_d;
   wave_t         target_q;
   wave_t         target_d;
   wave_t         wave_q;
   wave_t         wave_d;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_d;
   logic          chg_q;
   logic          chg_d;
   logic          busy_q;
   logic          busy_d;

   key_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db (
      .clk   (clk),
      .rst   (rst),
      .key   (mode_key),
      .press (press)
   );

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      wave_d   = wave_q;
      tmo_d    = tmo_q;
      chg_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // A wrap arriving with the press is ignored on purpose:
            // the switch waits for the next full wrap.
            if (press) begin
               target_d = wave_next(wave_q);
               tmo_d    = '0;
               state_d  = osc_en ? ST_WAIT_WRAP : ST_COMMIT;
            end
         end
         ST_WAIT_WRAP: begin
            // Extra presses advance the target but keep the timeout
            // running so a held-down stream cannot stall the commit.
            if (press) begin
               target_d = wave_next(target_q);
            end
            if (phase_wrap || !osc_en || (tmo_q == TMO_LAST)) begin
               state_d = ST_COMMIT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_COMMIT: begin
            wave_d = target_q;
            chg_d  = (target_q != wave_q);
            // A press landing here starts a fresh request from the
            // value being committed.
            if (press) begin
               target_d = wave_next(target_q);
               tmo_d    = '0;
               state_d  = osc_en ? ST_WAIT_WRAP : ST_COMMIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         target_q <= WAVE_SQUARE;
         wave_q   <= WAVE_SQUARE;
         tmo_q    <= '0;
         chg_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         wave_q   <= wave_d;
         tmo_q    <= tmo_d;
         chg_q    <= chg_d;
         busy_q   <= busy_d;
      end
   end

   assign wave_sel = wave_q;
   assign wave_chg = chg_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_wave_mode_ctrl.sv
// Directed bench for wave_mode_ctrl with DB_CYCLES=4, TIMEOUT_CYCLES=16.
// Inputs change and outputs are checked on the falling edge.
module tb_wave_mode_ctrl;
   import synth_pkg::*;

   logic  clk        = 1'b0;
   logic  rst        = 1'b1;
   logic  mode_key   = 1'b0;
   logic  phase_wrap = 1'b0;
   logic  osc_en     = 1'b0;
   wave_t wave_sel;
   logic  wave_chg;
   logic  busy;

   int errors   = 0;
   int checks   = 0;
   int chg_cnt  = 0;
   int busy_cnt = 0;
   int c0;
   int b0;

   wave_mode_ctrl #(
      .DB_CYCLES      (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode_key   (mode_key),
      .phase_wrap (phase_wrap),
      .osc_en     (osc_en),
      .wave_sel   (wave_sel),
      .wave_chg   (wave_chg),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wave_chg === 1'b1) chg_cnt <= chg_cnt + 1;
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns on the falling edge inside the press cycle.
   task automatic press_evt();
      mode_key = 1'b1;
      step(6);
      mode_key = 1'b0;
   endtask

   initial begin
      // reset state
      step(3);
      chk("rst_wave", 32'(wave_sel), 32'd0);
      chk("rst_chg", 32'(wave_chg), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // bouncing key: no press
      c0 = chg_cnt; b0 = busy_cnt;
      for (int i = 0; i < 10; i++) begin
         mode_key = (i % 2 == 0);
         step(2);
      end
      mode_key = 1'b0;
      step(12);
      chk("bounce_wave", 32'(wave_sel), 32'd0);
      chk("bounce_chg", 32'(chg_cnt - c0), 32'd0);
      chk("bounce_busy", 32'(busy_cnt - b0), 32'd0);

      // osc off: immediate commit 0 -> 1
      osc_en = 1'b0;
      c0 = chg_cnt; b0 = busy_cnt;
      press_evt();
      chk("off_busy_p", 32'(busy), 32'd0);
      step(1);
      chk("off_busy_c", 32'(busy), 32'd1);
      chk("off_wave_c", 32'(wave_sel), 32'd0);
      step(1);
      chk("off_wave", 32'(wave_sel), 32'd1);
      chk("off_chg", 32'(wave_chg), 32'd1);
      chk("off_busy_e", 32'(busy), 32'd0);
      step(1);
      chk("off_chg_e", 32'(wave_chg), 32'd0);
      step(8);
      chk("off_nchg", 32'(chg_cnt - c0), 32'd1);
      chk("off_nbusy", 32'(busy_cnt - b0), 32'd1);

      // osc on: wait for wrap 5 cycles after press, 1 -> 2
      osc_en = 1'b1;
      c0 = chg_cnt; b0 = busy_cnt;
      press_evt();
      step(1);
      chk("wrap_busy1", 32'(busy), 32'd1);
      step(4);
      chk("wrap_busy5", 32'(busy), 32'd1);
      chk("wrap_hold5", 32'(wave_sel), 32'd1);
      phase_wrap = 1'b1;
      step(1);
      phase_wrap = 1'b0;
      chk("wrap_hold6", 32'(wave_sel), 32'd1);
      chk("wrap_busy6", 32'(busy), 32'd1);
      step(1);
      chk("wrap_wave", 32'(wave_sel), 32'd2);
      chk("wrap_chg", 32'(wave_chg), 32'd1);
      chk("wrap_busy7", 32'(busy), 32'd0);
      step(3);
      chk("wrap_nchg", 32'(chg_cnt - c0), 32'd1);
      chk("wrap_nbusy", 32'(busy_cnt - b0), 32'd6);

      // timeout: no wrap, 2 -> 3 at n+18
      c0 = chg_cnt; b0 = busy_cnt;
      press_evt();
      step(16);
      chk("tmo_busy16", 32'(busy), 32'd1);
      chk("tmo_hold16", 32'(wave_sel), 32'd2);
      step(1);
      chk("tmo_hold17", 32'(wave_sel), 32'd2);
      chk("tmo_busy17", 32'(busy), 32'd1);
      step(1);
      chk("tmo_wave", 32'(wave_sel), 32'd3);
      chk("tmo_chg", 32'(wave_chg), 32'd1);
      chk("tmo_busy18", 32'(busy), 32'd0);
      step(2);
      chk("tmo_nchg", 32'(chg_cnt - c0), 32'd1);
      chk("tmo_nbusy", 32'(busy_cnt - b0), 32'd17);

      // wrap-around 3 -> 0 with osc off
      osc_en = 1'b0;
      press_evt();
      step(2);
      chk("wrap30_wave", 32'(wave_sel), 32'd0);
      chk("wrap30_chg", 32'(wave_chg), 32'd1);
      step(8);

      // osc_en drops 3 cycles after press: change at n+5
      osc_en = 1'b1;
      press_evt();
      step(3);
      chk("drop_busy3", 32'(busy), 32'd1);
      osc_en = 1'b0;
      step(1);
      chk("drop_hold4", 32'(wave_sel), 32'd0);
      chk("drop_busy4", 32'(busy), 32'd1);
      step(1);
      chk("drop_wave", 32'(wave_sel), 32'd1);
      chk("drop_chg", 32'(wave_chg), 32'd1);
      step(6);

      // wrap together with press in IDLE waits for the next wrap
      osc_en = 1'b1;
      press_evt();
      phase_wrap = 1'b1;
      step(1);
      phase_wrap = 1'b0;
      chk("sim_busy1", 32'(busy), 32'd1);
      step(2);
      chk("sim_busy3", 32'(busy), 32'd1);
      chk("sim_hold3", 32'(wave_sel), 32'd1);
      osc_en = 1'b0;
      step(2);
      chk("sim_wave", 32'(wave_sel), 32'd2);
      step(6);

      // two presses before the wrap: 0 -> 2, one wave_chg
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk("two_rst_wave", 32'(wave_sel), 32'd0);
      osc_en = 1'b1;
      c0 = chg_cnt;
      press_evt();
      step(6);
      press_evt();
      chk("two_busy", 32'(busy), 32'd1);
      chk("two_hold", 32'(wave_sel), 32'd0);
      step(1);
      phase_wrap = 1'b1;
      step(1);
      phase_wrap = 1'b0;
      chk("two_hold2", 32'(wave_sel), 32'd0);
      step(1);
      chk("two_wave", 32'(wave_sel), 32'd2);
      chk("two_chg", 32'(wave_chg), 32'd1);
      step(6);
      chk("two_nchg", 32'(chg_cnt - c0), 32'd1);

      // same, but reset while waiting discards the request
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      c0 = chg_cnt;
      press_evt();
      step(6);
      press_evt();
      step(1);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_wave", 32'(wave_sel), 32'd0);
      phase_wrap = 1'b1;
      step(1);
      phase_wrap = 1'b0;
      step(6);
      chk("rmid_wave_e", 32'(wave_sel), 32'd0);
      chk("rmid_nchg", 32'(chg_cnt - c0), 32'd0);

      // key held through reset: press DB_CYCLES+2 after release
      osc_en   = 1'b0;
      mode_key = 1'b1;
      rst      = 1'b1;
      step(3);
      rst = 1'b0;
      step(7);
      chk("held_hold", 32'(wave_sel), 32'd0);
      chk("held_busy", 32'(busy), 32'd1);
      step(1);
      chk("held_wave", 32'(wave_sel), 32'd1);
      chk("held_chg", 32'(wave_chg), 32'd1);
      mode_key = 1'b0;
      step(8);

      // press landing in COMMIT starts a new request: 1 -> 2 -> 3
      osc_en = 1'b1;
      c0 = chg_cnt;
      press_evt();
      step(6);
      mode_key = 1'b1;
      step(5);
      phase_wrap = 1'b1;
      step(1);
      phase_wrap = 1'b0;
      mode_key   = 1'b0;
      chk("pc_busy6", 32'(busy), 32'd1);
      chk("pc_hold6", 32'(wave_sel), 32'd1);
      step(1);
      chk("pc_wave7", 32'(wave_sel), 32'd2);
      chk("pc_chg7", 32'(wave_chg), 32'd1);
      chk("pc_busy7", 32'(busy), 32'd1);
      osc_en = 1'b0;
      step(1);
      chk("pc_chg8", 32'(wave_chg), 32'd0);
      chk("pc_busy8", 32'(busy), 32'd1);
      step(1);
      chk("pc_wave9", 32'(wave_sel), 32'd3);
      chk("pc_chg9", 32'(wave_chg), 32'd1);
      chk("pc_busy9", 32'(busy), 32'd0);
      step(4);
      chk("pc_nchg", 32'(chg_cnt - c0), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
